// File: rtl/gfx_ddr_write_arb.sv
// Two-client DDR2 write arbiter: locks the write path to one client for a whole burst.
// Define GFX_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed client-0 priority.

module gfx_ddr_write_arb #(
   parameter int unsigned BURST_BEATS = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [30:0]  c0_af_addr_din,
   input  logic         c0_af_wr_en,
   input  logic [127:0] c0_wdf_din,
   input  logic [15:0]  c0_wdf_mask_din,
   input  logic         c0_wdf_wr_en,
   output logic         c0_af_full,
   output logic         c0_wdf_full,
   input  logic [30:0]  c1_af_addr_din,
   input  logic         c1_af_wr_en,
   input  logic [127:0] c1_wdf_din,
   input  logic [15:0]  c1_wdf_mask_din,
   input  logic         c1_wdf_wr_en,
   output logic         c1_af_full,
   output logic         c1_wdf_full,
   input  logic         af_full,
   input  logic         wdf_full,
   output logic [30:0]  af_addr_din,
   output logic         af_wr_en,
   output logic [127:0] wdf_din,
   output logic [15:0]  wdf_mask_din,
   output logic         wdf_wr_en,
   output logic         owner
);

   localparam int unsigned     CntW    = $clog2(BURST_BEATS + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(BURST_BEATS - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic {StIdle, StLock} state_e;

   state_e          r_state, w_state_d;
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic            r_owner, w_owner_d;
   logic            w_win, w_pass, w_sel, w_first, w_sel_wdf_en, w_accept;
`ifdef GFX_ARB_ROUND_ROBIN_EN
   logic            r_ptr, w_ptr_d;
`endif

   always_comb begin
`ifdef GFX_ARB_ROUND_ROBIN_EN
      w_win = (c0_af_wr_en && c1_af_wr_en) ? r_ptr : ~c0_af_wr_en;
`else
      w_win = ~c0_af_wr_en;
`endif
   end

   always_comb begin
      w_pass  = 1'b0;
      w_sel   = 1'b0;
      w_first = 1'b0;
      if (!rst) begin
         case (r_state)
            StIdle: begin
               if (c0_af_wr_en || c1_af_wr_en) begin
                  w_pass  = 1'b1;
                  w_sel   = w_win;
                  w_first = 1'b1;
               end
            end
            StLock: begin
               w_pass = 1'b1;
               w_sel  = r_owner;
            end
            default: ;
         endcase
      end
   end

   // DDR2 enables fire only for a fully accepted beat, so address and data FIFOs stay in step
   assign w_sel_wdf_en = w_sel ? c1_wdf_wr_en : c0_wdf_wr_en;
   assign w_accept     = w_pass & w_sel_wdf_en & ~af_full & ~wdf_full;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_owner_d = r_owner;
`ifdef GFX_ARB_ROUND_ROBIN_EN
      w_ptr_d   = r_ptr;
`endif
      if (w_accept) begin
         if (w_first) begin
            if (BURST_BEATS > 1) begin
               w_state_d = StLock;
               w_owner_d = w_sel;
               w_cnt_d   = CntLoad;
            end
`ifdef GFX_ARB_ROUND_ROBIN_EN
            else begin
               w_ptr_d = ~w_sel;
            end
`endif
         end else begin
            w_cnt_d = r_cnt - CntOne;
            if (r_cnt == CntOne) begin
               w_state_d = StIdle;
`ifdef GFX_ARB_ROUND_ROBIN_EN
               w_ptr_d   = ~r_owner;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_owner <= 1'b0;
`ifdef GFX_ARB_ROUND_ROBIN_EN
         r_ptr   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_owner <= w_owner_d;
`ifdef GFX_ARB_ROUND_ROBIN_EN
         r_ptr   <= w_ptr_d;
`endif
      end
   end

   assign af_addr_din  = w_sel ? c1_af_addr_din  : c0_af_addr_din;
   assign wdf_din      = w_sel ? c1_wdf_din      : c0_wdf_din;
   assign wdf_mask_din = w_sel ? c1_wdf_mask_din : c0_wdf_mask_din;
   assign af_wr_en     = w_accept & w_first;
   assign wdf_wr_en    = w_accept;

   assign c0_af_full   = (w_pass && !w_sel) ? af_full  : 1'b1;
   assign c0_wdf_full  = (w_pass && !w_sel) ? wdf_full : 1'b1;
   assign c1_af_full   = (w_pass &&  w_sel) ? af_full  : 1'b1;
   assign c1_wdf_full  = (w_pass &&  w_sel) ? wdf_full : 1'b1;
   assign owner        = r_owner;

endmodule
